// File: rtl/issue_dispatcher.sv
// issue_dispatcher
//
// Buffers decoded instructions from the fetch unit in a circular instruction
// queue of 2**IQ_WIDTH entries. The queue head is issued to the RoB and the
// register file, and to the RS or the LSB over one shared registered payload
// bus. An issue is always followed by one idle cycle (GAP). That cycle gives
// the RoB time to advance its tail index and the RF rename time to land
// before the next head reads the RF.
//
// Ports
//   clk_in, rst_in, rdy_in        clock, synchronous active-high reset, enable
//   new_*                         push interface from IF, new_instruction_able = not full
//   RS_isFull/LSB_isFull/RoB_isFull   back-pressure from the issue targets
//   RoB_newEntryIndex             tag assigned to the instruction being issued
//   RoB_flush_signal              mispredict flush: empties the queue
//   CDB_en/CDB_robIndex/CDB_data  result broadcast, bypassed at issue time
//   RF_rs1/RF_rs2 (comb), RF_Q*/RF_V*   register file read of the queue head
//   RS_/LSB_newEntry_en, iss_*    registered payload to RS or LSB
//   RoB_*                         registered RoB allocation
//   RF_newEntry_en/robIndex/occupied_rd  registered rename request
module issue_dispatcher #(
    parameter int IQ_WIDTH  = 2,
    parameter int RoB_WIDTH = 3,
    parameter int NON_DEP   = 1 << RoB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    input  logic                 new_instruction_en,
    input  logic [31:0]          new_pc,
    input  logic [31:0]          new_imm,
    input  logic [6:0]           new_opcode,
    input  logic [4:0]           new_rs1,
    input  logic [4:0]           new_rs2,
    input  logic [4:0]           new_rd,
    input  logic                 new_predict_result,
    output logic                 new_instruction_able,

    input  logic                 RS_isFull,
    input  logic                 LSB_isFull,
    input  logic                 RoB_isFull,
    input  logic [RoB_WIDTH-1:0] RoB_newEntryIndex,
    input  logic                 RoB_flush_signal,

    input  logic                 CDB_en,
    input  logic [RoB_WIDTH-1:0] CDB_robIndex,
    input  logic [31:0]          CDB_data,

    output logic [4:0]           RF_rs1,
    output logic [4:0]           RF_rs2,
    input  logic [RoB_WIDTH:0]   RF_Qj,
    input  logic [RoB_WIDTH:0]   RF_Qk,
    input  logic [31:0]          RF_Vj,
    input  logic [31:0]          RF_Vk,

    output logic                 RS_newEntry_en,
    output logic                 LSB_newEntry_en,
    output logic [RoB_WIDTH-1:0] iss_robIndex,
    output logic [6:0]           iss_opcode,
    output logic [31:0]          iss_Vj,
    output logic [31:0]          iss_Vk,
    output logic [RoB_WIDTH:0]   iss_Qj,
    output logic [RoB_WIDTH:0]   iss_Qk,
    output logic [31:0]          iss_imm,
    output logic [31:0]          iss_pc,

    output logic                 RoB_newEntry_en,
    output logic [6:0]           RoB_opcode,
    output logic [4:0]           RoB_rd,
    output logic [31:0]          RoB_pc,
    output logic [31:0]          RoB_next_pc,
    output logic [31:0]          RoB_ready_data,
    output logic                 RoB_predict_result,
    output logic                 RoB_already_ready,

    output logic                 RF_newEntry_en,
    output logic [RoB_WIDTH-1:0] RF_newEntry_robIndex,
    output logic [4:0]           RF_occupied_rd
);

    localparam int DEPTH = 1 << IQ_WIDTH;
    localparam logic [RoB_WIDTH:0] NON_DEP_TAG = (RoB_WIDTH+1)'(NON_DEP);
    localparam logic [IQ_WIDTH:0]  DEPTH_CNT   = (IQ_WIDTH+1)'(DEPTH);
    localparam logic [IQ_WIDTH-1:0] PTR_ONE    = (IQ_WIDTH)'(1);
    localparam logic [IQ_WIDTH:0]  CNT_ONE     = (IQ_WIDTH+1)'(1);

    // Internal opcode enumeration (contiguous groups per format)
    localparam logic [6:0] OP_LUI   = 7'd1;
    localparam logic [6:0] OP_AUIPC = 7'd2;
    localparam logic [6:0] OP_JAL   = 7'd3;
    localparam logic [6:0] OP_JALR  = 7'd4;
    localparam logic [6:0] OP_BEQ   = 7'd5;
    localparam logic [6:0] OP_BGEU  = 7'd10;
    localparam logic [6:0] OP_LB    = 7'd11;
    localparam logic [6:0] OP_LHU   = 7'd15;
    localparam logic [6:0] OP_SB    = 7'd16;
    localparam logic [6:0] OP_SW    = 7'd18;
    localparam logic [6:0] OP_ADDI  = 7'd19;
    localparam logic [6:0] OP_SRAI  = 7'd27;
    localparam logic [6:0] OP_ADD   = 7'd28;
    localparam logic [6:0] OP_ANDR  = 7'd37;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_GAP   = 1'b1
    } state_t;

    // ---------------- opcode classification ----------------
    function automatic logic is_branch(input logic [6:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [6:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic is_ialu(input logic [6:0] op);
        return (op >= OP_ADDI) && (op <= OP_SRAI);
    endfunction

    function automatic logic is_rtype(input logic [6:0] op);
        return (op >= OP_ADD) && (op <= OP_ANDR);
    endfunction

    function automatic logic goes_rs(input logic [6:0] op);
        return (op == OP_JALR) || is_branch(op) || is_ialu(op) || is_rtype(op);
    endfunction

    function automatic logic goes_lsb(input logic [6:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return goes_rs(op) || goes_lsb(op);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return is_branch(op) || is_store(op) || is_rtype(op);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR)
            || is_load(op) || is_ialu(op) || is_rtype(op);
    endfunction

    // ---------------- operand resolve (RF tag, then CDB bypass) ----------------
    function automatic logic [RoB_WIDTH:0] resolve_q(
        input logic                 used,
        input logic [RoB_WIDTH:0]   rf_q,
        input logic                 cdb_en,
        input logic [RoB_WIDTH-1:0] cdb_idx
    );
        if (!used || rf_q == NON_DEP_TAG)
            return NON_DEP_TAG;
        if (cdb_en && cdb_idx == rf_q[RoB_WIDTH-1:0])
            return NON_DEP_TAG;
        return rf_q;
    endfunction

    function automatic logic [31:0] resolve_v(
        input logic                 used,
        input logic [RoB_WIDTH:0]   rf_q,
        input logic [31:0]          rf_v,
        input logic                 cdb_en,
        input logic [RoB_WIDTH-1:0] cdb_idx,
        input logic [31:0]          cdb_data
    );
        if (!used)
            return 32'd0;
        if (rf_q == NON_DEP_TAG)
            return rf_v;
        if (cdb_en && cdb_idx == rf_q[RoB_WIDTH-1:0])
            return cdb_data;
        return 32'd0;
    endfunction

    // ---------------- queue storage and control ----------------
    logic [31:0] q_pc   [DEPTH];
    logic [31:0] q_imm  [DEPTH];
    logic [6:0]  q_op   [DEPTH];
    logic [4:0]  q_rs1  [DEPTH];
    logic [4:0]  q_rs2  [DEPTH];
    logic [4:0]  q_rd   [DEPTH];
    logic        q_pred [DEPTH];

    logic [IQ_WIDTH-1:0] head, tail;
    logic [IQ_WIDTH:0]   count;
    state_t              state, state_next;

    logic        empty, push, issue, target_full;
    logic [31:0] h_pc, h_imm;
    logic [6:0]  h_op;
    logic [4:0]  h_rs1, h_rs2, h_rd;
    logic        h_pred;

    logic [RoB_WIDTH:0] res_qj, res_qk;
    logic [31:0]        res_vj, res_vk;
    logic [31:0]        nxt_pc, rdy_data;
    logic               rdy_flag, pred_flag, rename;
    logic [4:0]         rob_rd;

    assign empty                = (count == '0);
    assign new_instruction_able = (count < DEPTH_CNT);
    assign push = rdy_in && !RoB_flush_signal && new_instruction_en && new_instruction_able;

    assign h_pc   = q_pc[head];
    assign h_imm  = q_imm[head];
    assign h_op   = q_op[head];
    assign h_rs1  = q_rs1[head];
    assign h_rs2  = q_rs2[head];
    assign h_rd   = q_rd[head];
    assign h_pred = q_pred[head];

    // Register read addresses are forced to x0 for absent operands and for an
    // empty queue, so the RF never sees stale slot contents.
    assign RF_rs1 = (!empty && uses_rs1(h_op)) ? h_rs1 : 5'd0;
    assign RF_rs2 = (!empty && uses_rs2(h_op)) ? h_rs2 : 5'd0;

    assign target_full = (goes_rs(h_op) && RS_isFull) || (goes_lsb(h_op) && LSB_isFull);

    // ---------------- issue FSM: next state ----------------
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        if (RoB_flush_signal) begin
            state_next = ST_READY;
        end else if (rdy_in) begin
            case (state)
                ST_READY: begin
                    if (!empty && !RoB_isFull && !target_full) begin
                        issue      = 1'b1;
                        state_next = ST_GAP;
                    end
                end
                ST_GAP:  state_next = ST_READY;
                default: state_next = ST_READY;
            endcase
        end
    end

    // ---------------- head decode for the issue payload ----------------
    always_comb begin
        res_qj    = resolve_q(uses_rs1(h_op), RF_Qj, CDB_en, CDB_robIndex);
        res_qk    = resolve_q(uses_rs2(h_op), RF_Qk, CDB_en, CDB_robIndex);
        res_vj    = resolve_v(uses_rs1(h_op), RF_Qj, RF_Vj, CDB_en, CDB_robIndex, CDB_data);
        res_vk    = resolve_v(uses_rs2(h_op), RF_Qk, RF_Vk, CDB_en, CDB_robIndex, CDB_data);
        nxt_pc    = h_pc + 32'd4;
        rdy_data  = 32'd0;
        rdy_flag  = 1'b0;
        pred_flag = 1'b0;
        case (h_op)
            OP_LUI: begin
                rdy_flag = 1'b1;
                rdy_data = h_imm;
            end
            OP_AUIPC: begin
                rdy_flag = 1'b1;
                rdy_data = h_pc + h_imm;
            end
            OP_JAL: begin
                rdy_flag = 1'b1;
                rdy_data = h_pc + 32'd4;
                nxt_pc   = h_pc + h_imm;
            end
            default: begin
                if (is_branch(h_op)) begin
                    nxt_pc    = h_pc + h_imm;
                    pred_flag = h_pred;
                end
            end
        endcase
        rob_rd = (is_branch(h_op) || is_store(h_op)) ? 5'd0 : h_rd;
        rename = writes_rd(h_op) && (h_rd != 5'd0);
    end

    // ---------------- queue write (data only) ----------------
    always_ff @(posedge clk_in) begin
        if (push) begin
            q_pc[tail]   <= new_pc;
            q_imm[tail]  <= new_imm;
            q_op[tail]   <= new_opcode;
            q_rs1[tail]  <= new_rs1;
            q_rs2[tail]  <= new_rs2;
            q_rd[tail]   <= new_rd;
            q_pred[tail] <= new_predict_result;
        end
    end

    // ---------------- queue pointers and FSM state ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= ST_READY;
        end else begin
            state <= state_next;
            if (RoB_flush_signal) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (rdy_in) begin
                if (push)
                    tail <= tail + PTR_ONE;
                if (issue)
                    head <= head + PTR_ONE;
                case ({push, issue})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // ---------------- issue output registers ----------------
    // issue is already low during flush and pause, so the enables drop to 0.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            RS_newEntry_en       <= 1'b0;
            LSB_newEntry_en      <= 1'b0;
            RoB_newEntry_en      <= 1'b0;
            RF_newEntry_en       <= 1'b0;
            iss_robIndex         <= '0;
            iss_opcode           <= '0;
            iss_Vj               <= '0;
            iss_Vk               <= '0;
            iss_Qj               <= '0;
            iss_Qk               <= '0;
            iss_imm              <= '0;
            iss_pc               <= '0;
            RoB_opcode           <= '0;
            RoB_rd               <= '0;
            RoB_pc               <= '0;
            RoB_next_pc          <= '0;
            RoB_ready_data       <= '0;
            RoB_predict_result   <= 1'b0;
            RoB_already_ready    <= 1'b0;
            RF_newEntry_robIndex <= '0;
            RF_occupied_rd       <= '0;
        end else begin
            RS_newEntry_en  <= issue && goes_rs(h_op);
            LSB_newEntry_en <= issue && goes_lsb(h_op);
            RoB_newEntry_en <= issue;
            RF_newEntry_en  <= issue && rename;
            if (issue) begin
                iss_robIndex         <= RoB_newEntryIndex;
                iss_opcode           <= h_op;
                iss_Vj               <= res_vj;
                iss_Vk               <= res_vk;
                iss_Qj               <= res_qj;
                iss_Qk               <= res_qk;
                iss_imm              <= h_imm;
                iss_pc               <= h_pc;
                RoB_opcode           <= h_op;
                RoB_rd               <= rob_rd;
                RoB_pc               <= h_pc;
                RoB_next_pc          <= nxt_pc;
                RoB_ready_data       <= rdy_data;
                RoB_predict_result   <= pred_flag;
                RoB_already_ready    <= rdy_flag;
                RF_newEntry_robIndex <= RoB_newEntryIndex;
                RF_occupied_rd       <= h_rd;
            end
        end
    end

endmodule

// File: tb/tb_issue_dispatcher.sv
// Directed bench for issue_dispatcher (IQ_WIDTH=2, RoB_WIDTH=3, NON_DEP=8).
// Inputs change 1 time unit after a rising edge; registered outputs are
// checked at that same point, i.e. they show what the previous edge loaded.
module tb_issue_dispatcher;

    localparam logic [6:0] LUI = 7'd1, JAL = 7'd3, BEQ = 7'd5, LW = 7'd13,
                           SW = 7'd18, ADDI = 7'd19, ADD = 7'd28;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        new_instruction_en;
    logic [31:0] new_pc, new_imm;
    logic [6:0]  new_opcode;
    logic [4:0]  new_rs1, new_rs2, new_rd;
    logic        new_predict_result;
    logic        new_instruction_able;
    logic        RS_isFull, LSB_isFull, RoB_isFull;
    logic [2:0]  RoB_newEntryIndex;
    logic        RoB_flush_signal;
    logic        CDB_en;
    logic [2:0]  CDB_robIndex;
    logic [31:0] CDB_data;
    logic [4:0]  RF_rs1, RF_rs2;
    logic [3:0]  RF_Qj, RF_Qk;
    logic [31:0] RF_Vj, RF_Vk;
    logic        RS_newEntry_en, LSB_newEntry_en;
    logic [2:0]  iss_robIndex;
    logic [6:0]  iss_opcode;
    logic [31:0] iss_Vj, iss_Vk, iss_imm, iss_pc;
    logic [3:0]  iss_Qj, iss_Qk;
    logic        RoB_newEntry_en;
    logic [6:0]  RoB_opcode;
    logic [4:0]  RoB_rd;
    logic [31:0] RoB_pc, RoB_next_pc, RoB_ready_data;
    logic        RoB_predict_result, RoB_already_ready;
    logic        RF_newEntry_en;
    logic [2:0]  RF_newEntry_robIndex;
    logic [4:0]  RF_occupied_rd;

    // {RS, LSB, RoB, RF} enables
    logic [3:0]  ens;
    assign ens = {RS_newEntry_en, LSB_newEntry_en, RoB_newEntry_en, RF_newEntry_en};

    int n_cmp = 0;
    int n_err = 0;

    issue_dispatcher #(.IQ_WIDTH(2), .RoB_WIDTH(3), .NON_DEP(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .new_instruction_en(new_instruction_en), .new_pc(new_pc), .new_imm(new_imm),
        .new_opcode(new_opcode), .new_rs1(new_rs1), .new_rs2(new_rs2), .new_rd(new_rd),
        .new_predict_result(new_predict_result), .new_instruction_able(new_instruction_able),
        .RS_isFull(RS_isFull), .LSB_isFull(LSB_isFull), .RoB_isFull(RoB_isFull),
        .RoB_newEntryIndex(RoB_newEntryIndex), .RoB_flush_signal(RoB_flush_signal),
        .CDB_en(CDB_en), .CDB_robIndex(CDB_robIndex), .CDB_data(CDB_data),
        .RF_rs1(RF_rs1), .RF_rs2(RF_rs2), .RF_Qj(RF_Qj), .RF_Qk(RF_Qk),
        .RF_Vj(RF_Vj), .RF_Vk(RF_Vk),
        .RS_newEntry_en(RS_newEntry_en), .LSB_newEntry_en(LSB_newEntry_en),
        .iss_robIndex(iss_robIndex), .iss_opcode(iss_opcode),
        .iss_Vj(iss_Vj), .iss_Vk(iss_Vk), .iss_Qj(iss_Qj), .iss_Qk(iss_Qk),
        .iss_imm(iss_imm), .iss_pc(iss_pc),
        .RoB_newEntry_en(RoB_newEntry_en), .RoB_opcode(RoB_opcode), .RoB_rd(RoB_rd),
        .RoB_pc(RoB_pc), .RoB_next_pc(RoB_next_pc), .RoB_ready_data(RoB_ready_data),
        .RoB_predict_result(RoB_predict_result), .RoB_already_ready(RoB_already_ready),
        .RF_newEntry_en(RF_newEntry_en), .RF_newEntry_robIndex(RF_newEntry_robIndex),
        .RF_occupied_rd(RF_occupied_rd)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic pred);
        new_instruction_en = 1'b1;
        new_opcode = op; new_pc = pc; new_imm = imm;
        new_rs1 = rs1; new_rs2 = rs2; new_rd = rd; new_predict_result = pred;
    endtask

    task automatic nopush();
        new_instruction_en = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        new_instruction_en = 1'b0; new_pc = '0; new_imm = '0; new_opcode = '0;
        new_rs1 = '0; new_rs2 = '0; new_rd = '0; new_predict_result = 1'b0;
        RS_isFull = 1'b0; LSB_isFull = 1'b0; RoB_isFull = 1'b0;
        RoB_newEntryIndex = 3'd0; RoB_flush_signal = 1'b0;
        CDB_en = 1'b0; CDB_robIndex = '0; CDB_data = '0;
        RF_Qj = 4'd8; RF_Qk = 4'd8; RF_Vj = '0; RF_Vk = '0;
        step(); step();
        rst_in = 1'b0;

        // ---- reset state ----
        chk("rst_ens", ens, 4'b0000);
        chk("rst_already_ready", RoB_already_ready, 1'b0);
        chk("rst_able", new_instruction_able, 1'b1);
        chk("rst_next_pc", RoB_next_pc, 32'd0);
        chk("rst_iss_Qj", iss_Qj, 4'd0);

        // ---- lui / addi / sw back to back ----
        push(LUI, 32'h0, 32'h12345000, 5'd0, 5'd0, 5'd1, 1'b0);
        step();
        push(ADDI, 32'h4, 32'h1, 5'd1, 5'd0, 5'd2, 1'b0);
        chk("lui_rf_rs1", RF_rs1, 5'd0);
        chk("lui_ens_pre", ens, 4'b0000);
        step();
        chk("lui_ens", ens, 4'b0011);
        chk("lui_data", RoB_ready_data, 32'h12345000);
        chk("lui_ready", RoB_already_ready, 1'b1);
        chk("lui_next_pc", RoB_next_pc, 32'h4);
        chk("lui_rd", RF_occupied_rd, 5'd1);
        chk("lui_tag", RF_newEntry_robIndex, 3'd0);
        chk("addi_rf_rs1", RF_rs1, 5'd1);
        push(SW, 32'h8, 32'h0, 5'd0, 5'd2, 5'd3, 1'b0);
        RoB_newEntryIndex = 3'd1;
        RF_Qj = 4'd0; RF_Vj = 32'd0;
        step();
        nopush();
        chk("gap1_ens", ens, 4'b0000);
        step();
        chk("addi_ens", ens, 4'b1011);
        chk("addi_Qj", iss_Qj, 4'd0);
        chk("addi_Vj", iss_Vj, 32'd0);
        chk("addi_Qk", iss_Qk, 4'd8);
        chk("addi_imm", iss_imm, 32'h1);
        chk("addi_robidx", iss_robIndex, 3'd1);
        chk("addi_rd", RoB_rd, 5'd2);
        chk("addi_next_pc", RoB_next_pc, 32'h8);
        chk("addi_ready", RoB_already_ready, 1'b0);
        chk("sw_rf_rs2", RF_rs2, 5'd2);
        RoB_newEntryIndex = 3'd2;
        RF_Qj = 4'd8; RF_Vj = 32'd0; RF_Qk = 4'd1; RF_Vk = 32'd0;
        step();
        chk("gap2_ens", ens, 4'b0000);
        step();
        chk("sw_ens", ens, 4'b0110);
        chk("sw_rob_rd", RoB_rd, 5'd0);
        chk("sw_Qk", iss_Qk, 4'd1);
        chk("sw_robidx", iss_robIndex, 3'd2);
        RF_Qk = 4'd8;

        // ---- fill the queue with loads while the LSB is full ----
        LSB_isFull = 1'b1;
        RF_Qj = 4'd8; RF_Vj = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            push(LW, 32'h20 + 32'(4 * i), 32'(4 * i), 5'd10, 5'd0, 5'(5 + i), 1'b0);
            step();
        end
        chk("full_able", new_instruction_able, 1'b0);
        chk("full_ens", ens, 4'b0000);
        push(ADDI, 32'h60, 32'h7, 5'd1, 5'd0, 5'd20, 1'b0);
        step();
        nopush();
        chk("full_able2", new_instruction_able, 1'b0);
        chk("full_ens2", ens, 4'b0000);
        step();
        chk("blocked_ens", ens, 4'b0000);
        LSB_isFull = 1'b0;
        step();
        chk("ld0_ens", ens, 4'b0111);
        chk("ld0_rd", RoB_rd, 5'd5);
        chk("ld0_Vj", iss_Vj, 32'h1000);
        chk("ld0_able", new_instruction_able, 1'b1);
        step();
        chk("ld_gap_ens", ens, 4'b0000);
        step();
        chk("ld1_ens", ens, 4'b0111);
        chk("ld1_rd", RoB_rd, 5'd6);
        step(); step();
        chk("ld2_rd", RoB_rd, 5'd7);
        step(); step();
        chk("ld3_rd", RoB_rd, 5'd8);
        chk("ld3_ens", ens, 4'b0111);
        step(); step(); step();
        chk("refused_push_ens", ens, 4'b0000);
        RF_Vj = 32'd0;

        // ---- CDB bypass at issue ----
        push(ADD, 32'h40, 32'h0, 5'd4, 5'd5, 5'd3, 1'b0);
        step();
        nopush();
        RF_Qj = 4'd3; RF_Vj = 32'h1111;
        RF_Qk = 4'd4; RF_Vk = 32'h77;
        CDB_en = 1'b1; CDB_robIndex = 3'd3; CDB_data = 32'hDEADBEEF;
        step();
        chk("cdb_ens", ens, 4'b1011);
        chk("cdb_Vj", iss_Vj, 32'hDEADBEEF);
        chk("cdb_Qj", iss_Qj, 4'd8);
        chk("cdb_Qk_nomatch", iss_Qk, 4'd4);
        chk("cdb_Vk_nomatch", iss_Vk, 32'd0);
        CDB_en = 1'b0; RF_Qj = 4'd8; RF_Vj = '0; RF_Qk = 4'd8; RF_Vk = '0;

        // ---- flush with a full queue and a coincident push ----
        LSB_isFull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(LW, 32'h80 + 32'(4 * i), 32'd0, 5'd10, 5'd0, 5'(11 + i), 1'b0);
            step();
        end
        nopush();
        chk("fl_pre_able", new_instruction_able, 1'b0);
        RoB_flush_signal = 1'b1;
        LSB_isFull = 1'b0;
        push(ADDI, 32'h90, 32'h1, 5'd1, 5'd0, 5'd21, 1'b0);
        step();
        RoB_flush_signal = 1'b0;
        nopush();
        chk("fl_able", new_instruction_able, 1'b1);
        chk("fl_ens", ens, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_after_ens", ens, 4'b0000);
        end

        // ---- jal writing x0, then a predicted branch ----
        push(JAL, 32'h100, 32'h20, 5'd7, 5'd0, 5'd0, 1'b0);
        step();
        nopush();
        chk("jal_rf_rs1", RF_rs1, 5'd0);
        step();
        chk("jal_ens", ens, 4'b0010);
        chk("jal_next_pc", RoB_next_pc, 32'h120);
        chk("jal_data", RoB_ready_data, 32'h104);
        chk("jal_ready", RoB_already_ready, 1'b1);
        push(BEQ, 32'h200, 32'h10, 5'd1, 5'd2, 5'd6, 1'b1);
        step();
        nopush();
        step();
        chk("beq_ens", ens, 4'b1010);
        chk("beq_next_pc", RoB_next_pc, 32'h210);
        chk("beq_pred", RoB_predict_result, 1'b1);
        chk("beq_rd", RoB_rd, 5'd0);

        // ---- pause for three cycles mid-stream ----
        push(ADDI, 32'h300, 32'h1, 5'd0, 5'd0, 5'd15, 1'b0);
        step();
        push(ADDI, 32'h304, 32'h2, 5'd0, 5'd0, 5'd16, 1'b0);
        step();
        chk("pa_A_ens", ens, 4'b1011);
        chk("pa_A_rd", RoB_rd, 5'd15);
        rdy_in = 1'b0;
        push(ADDI, 32'h308, 32'h3, 5'd0, 5'd0, 5'd17, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pa_hold_ens", ens, 4'b0000);
        end
        rdy_in = 1'b1;
        nopush();
        step();
        chk("pa_resume_gap", ens, 4'b0000);
        step();
        chk("pa_B_ens", ens, 4'b1011);
        chk("pa_B_rd", RoB_rd, 5'd16);
        chk("pa_B_pc", RoB_pc, 32'h304);
        step(); step(); step();
        chk("pa_dropped_push", ens, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
